mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter and sequencer for the 4-to-1 multiplexer datapath. Four requesters compete for the shared mux output. The block grants exactly one of them at a time, drives the mux 2-bit select with the winner's index, and rotates priority so no requester is starved. It sits directly in front of the mux select input; requester 0 maps to mux input a (select 2'b00), requester 3 maps to input d (select 2'b11).

## Interface
- MAX_HOLD, 8: maximum consecutive cycles one owner may hold the grant while others wait (only active with the hold-limit feature); legal range 2..256.

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  level request per requester; bit i = requester i
- gnt  output  4  one-hot grant, registered; all-zero when no owner
- select  output  2  mux select = index of current owner, registered
- valid  output  1  high while an owner holds the grant (equals |gnt)

## Operation
- State machine: IDLE, BUSY. Registers: state, owner index, rotating pointer ptr (2 bits), hold counter cnt.
- Arbitration function: scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4) and pick the first with req set.
- IDLE:
  - If req != 0, go to BUSY next cycle with owner = arbitration winner, gnt = one-hot(owner), select = owner, valid = 1, cnt = 0.
  - Otherwise stay in IDLE.
- BUSY, owner keeps req[owner] = 1: hold the grant and increment cnt, which saturates at MAX_HOLD-1.
- BUSY, owner drops req[owner] (release):
  - Set ptr = owner+1 mod 4.
  - In the same cycle, arbitrate with that new ptr over the current req.
  - If there is a winner, grant it next cycle, so handover has zero bubble.
  - If there is no winner, go to IDLE with gnt = 0, valid = 0.
- Wrap-around: after owner 3 releases, ptr = 0.
- select is not cleared on entering IDLE; it holds the last owner's index so the mux output stays stable.
- Simultaneous requests from IDLE after reset (ptr = 0), e.g. req = 4'b1010: requester 1 wins.
- A new request arriving in the same cycle the owner releases takes part in that cycle's arbitration.
- cnt width is clog2(MAX_HOLD) bits and resets to 0 on every new grant.

## Timing
- Reset values: gnt = 4'b0000, select = 2'b00, valid = 0, state = IDLE, ptr = 0, cnt = 0.
- Reset takes effect at the next rising edge and has priority over all other events, including mid-grant.
- Latency from req assertion (IDLE) to gnt/select/valid: 1 cycle.
- Latency from owner req deassertion to grant removal or handover: 1 cycle.
- Outputs are registered and do not depend combinationally on req.
- Invariants, checked every cycle:
  - gnt is one-hot or zero.
  - valid == |gnt.
  - When valid = 1, gnt[select] == 1.

## Configuration
- Macro MUX_ARB_HOLD_LIMIT_EN.
- Defined (preemption on):
  - In BUSY, if cnt == MAX_HOLD-1 and any other requester has req set, the owner is preempted even with req[owner] still high.
  - Then ptr = owner+1, arbitration excludes the current owner, and the winner is granted next cycle.
  - If no other requester is waiting, the owner keeps the grant and cnt stays at MAX_HOLD-1.
- Undefined (no preemption):
  - The grant is released only by deasserting req.
  - cnt and the preemption logic are not compiled in.
  - MAX_HOLD is ignored.

## Test plan
- Reset check: assert rst for 2 cycles with req = 4'b1111 -> gnt = 0, select = 0, valid = 0. Release rst -> next cycle gnt = 4'b0001, select = 2'b00.
- Rotation: hold req = 4'b1111 and have each owner drop its req for one cycle after 3 cycles of ownership -> grant order 0, 1, 2, 3, 0 with zero idle cycles between owners.
- Idle and hold: grant requester 2, then set req = 0 -> next cycle valid = 0, gnt = 0, select still 2'b10. Then req = 4'b0001 -> gnt = 4'b0001 one cycle later.
- Reset mid-grant: requester 3 owns the grant and rst pulses one cycle -> outputs zero next cycle, ptr = 0. Then req = 4'b1001 -> requester 0 wins.
- With MUX_ARB_HOLD_LIMIT_EN defined and MAX_HOLD = 4: req = 4'b0011 held constant -> owner 0 for 4 cycles, then owner 1 for 4 cycles, alternating. With only req = 4'b0001 -> owner 0 holds indefinitely.
- Without the macro, same stimulus req = 4'b0011 held -> owner 0 holds indefinitely and requester 1 is never granted.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a 4:1 mux; one owner at a time, zero-bubble handover.
// Optional hold-limit preemption is compiled in with `define MUX_ARB_HOLD_LIMIT_EN (limit = MAX_HOLD cycles).
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] select,
  output logic       valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [1:0] owner;
  logic [1:0] ptr;

  logic [1:0] base_c;
  logic [3:0] cand_c;
  logic [1:0] scan_idx_c;
  logic [1:0] win_c;
  logic       win_found_c;
  logic       release_c;
  logic       preempt_c;

  // MAX_HOLD outside 2..256 is not a supported configuration.
  localparam bit HOLD_RANGE_OK = (MAX_HOLD >= 2) && (MAX_HOLD <= 256);
  if (!HOLD_RANGE_OK) begin : g_bad_max_hold
  end

  // Priority scan from base; while busy the current owner is never a candidate.
  always_comb begin
    base_c      = (state == BUSY) ? owner + 2'd1 : ptr;
    cand_c      = req;
    if (state == BUSY) cand_c[owner] = 1'b0;
    scan_idx_c  = base_c;
    win_c       = base_c;
    win_found_c = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      scan_idx_c = base_c + 2'(i);
      if (cand_c[scan_idx_c]) begin
        win_c       = scan_idx_c;
        win_found_c = 1'b1;
      end
    end
  end

  assign release_c = !req[owner];

`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] cnt;

  // Preempt only when someone else is actually waiting.
  assign preempt_c = (cnt == CNT_MAX) && win_found_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == IDLE || release_c || preempt_c) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  assign preempt_c = 1'b0;
`endif

  // Arbiter state machine with registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 2'd0;
      ptr   <= 2'd0;
      gnt   <= 4'b0000;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found_c) begin
            state <= BUSY;
            owner <= win_c;
            gnt   <= 4'b0001 << win_c;
            valid <= 1'b1;
          end
        end
        BUSY: begin
          if (release_c || preempt_c) begin
            ptr <= owner + 2'd1;
            if (win_found_c) begin
              owner <= win_c;
              gnt   <= 4'b0001 << win_c;
              valid <= 1'b1;
            end else begin
              state <= IDLE;
              gnt   <= 4'b0000;
              valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Owner index persists through IDLE so the mux output stays stable.
  assign select = owner;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter; expected grants are hand-computed.
// Hold-limit expectations follow `define MUX_ARB_HOLD_LIMIT_EN with MAX_HOLD = 4.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] select;
  logic       valid;

  int checks = 0;
  int errors = 0;

  mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt    (gnt),
    .select (select),
    .valid  (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] s, input logic v);
    check({tag, "_gnt"}, 32'(gnt), 32'(g));
    check({tag, "_sel"}, 32'(select), 32'(s));
    check({tag, "_valid"}, 32'(valid), 32'(v));
  endtask

  // Structural invariants sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("inv_onehot", 32'($onehot0(gnt)), 32'd1);
      check("inv_valid", 32'(valid), 32'(|gnt));
      if (valid) check("inv_gnt_sel", 32'(gnt[select]), 32'd1);
    end
  end

  initial begin
    logic [3:0] exp_g;

    // Reset with all requesters active.
    rst = 1'b1;
    req = 4'b1111;
    tick();
    tick();
    expect_out("reset", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    tick();
    expect_out("post_reset", 4'b0001, 2'd0, 1'b1);

    // Rotation: each owner keeps the grant 3 cycles, then drops for one cycle.
    for (int k = 0; k < 4; k++) begin
      exp_g = 4'(1 << k);
      for (int c = 0; c < 3; c++) begin
        expect_out("rot_hold", exp_g, 2'(k), 1'b1);
        if (c < 2) tick();
      end
      req = 4'b1111 & ~exp_g;
      tick();
      req = 4'b1111;
    end
    expect_out("rot_wrap", 4'b0001, 2'd0, 1'b1);

    // Hand to requester 2, then go idle; select must hold 2.
    req = 4'b0100;
    tick();
    expect_out("to_req2", 4'b0100, 2'd2, 1'b1);
    req = 4'b0000;
    tick();
    expect_out("idle_hold_sel", 4'b0000, 2'd2, 1'b0);
    tick();
    expect_out("idle_stay", 4'b0000, 2'd2, 1'b0);
    req = 4'b0001;
    tick();
    expect_out("idle_to_0", 4'b0001, 2'd0, 1'b1);

    // Release to idle leaves ptr = 1, so requester 3 beats requester 0.
    req = 4'b0000;
    tick();
    expect_out("idle_again", 4'b0000, 2'd0, 1'b0);
    req = 4'b1001;
    tick();
    expect_out("ptr_pick3", 4'b1000, 2'd3, 1'b1);

    // Reset while requester 3 owns the grant.
    rst = 1'b1;
    tick();
    expect_out("mid_reset", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    tick();
    expect_out("after_mid_reset", 4'b0001, 2'd0, 1'b1);

    // Simultaneous requests from a fresh reset.
    rst = 1'b1;
    req = 4'b1010;
    tick();
    rst = 1'b0;
    tick();
    expect_out("simul_1010", 4'b0010, 2'd1, 1'b1);

    // Two requesters held constant.
    rst = 1'b1;
    req = 4'b0011;
    tick();
    rst = 1'b0;
    tick();
    for (int c = 0; c < 16; c++) begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
      exp_g = (((c / 4) % 2) == 1) ? 4'b0010 : 4'b0001;
`else
      exp_g = 4'b0001;
`endif
      check("hold_0011", 32'(gnt), 32'(exp_g));
      tick();
    end

    // Lone requester keeps the grant regardless of hold limit.
    rst = 1'b1;
    req = 4'b0001;
    tick();
    rst = 1'b0;
    tick();
    for (int c = 0; c < 10; c++) begin
      expect_out("hold_lone", 4'b0001, 2'd0, 1'b1);
      tick();
    end

    // New request arriving in the release cycle is granted with no bubble.
    req = 4'b0100;
    tick();
    expect_out("release_join", 4'b0100, 2'd2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
